r_type_pipe: RTL and testbench

- Parametrised, two-stage pipelined R-type execution unit: register file, MIPS-funct ALU, and writeback behind a valid/ready handshake.
- Successor to the single-cycle R-type datapath, adding:
  - generic width and depth
  - a hardwired zero register
  - operand forwarding and backpressure
  - overflow-trap writeback suppression
  - illegal-funct detection
  - a debug access port
- Sits between the instruction decoder (upstream) and the retire/commit logic (downstream).

---
 rtl/r_type_pkg.sv | 46 ++++
 rtl/r_type_if.sv | 29 ++
 rtl/alu_param.sv | 48 ++++
 rtl/r_type_pipe.sv | 171 +++++++++++++++++
 tb/tb_r_type_pipe.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/r_type_pkg.sv
// Shared definitions for the R-type execution slice: MIPS funct codes,
// internal ALU op encodings and the funct-to-op decoder.
package r_type_pkg;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDU = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBU = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_ILL  = 4'd15;

  function automatic logic [3:0] decode_funct(input logic [5:0] funct);
    logic [3:0] op;
    case (funct)
      FUNCT_ADD:  op = OP_ADD;
      FUNCT_ADDU: op = OP_ADDU;
      FUNCT_SUB:  op = OP_SUB;
      FUNCT_SUBU: op = OP_SUBU;
      FUNCT_AND:  op = OP_AND;
      FUNCT_OR:   op = OP_OR;
      FUNCT_XOR:  op = OP_XOR;
      FUNCT_NOR:  op = OP_NOR;
      FUNCT_SLT:  op = OP_SLT;
      FUNCT_SLTU: op = OP_SLTU;
      default:    op = OP_ILL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/r_type_if.sv
// Issue/result handshake bundle between decoder, R-type unit and retire logic.
interface r_type_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [AW-1:0]    rs;
  logic [AW-1:0]    rt;
  logic [AW-1:0]    rd;
  logic [5:0]       funct;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [AW-1:0]    out_rd;
  logic             out_overflow;
  logic             out_zero;
  logic             out_illegal;

  modport master (
    output in_valid, rs, rt, rd, funct, out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_overflow, out_zero, out_illegal
  );

  modport slave (
    input  in_valid, rs, rt, rd, funct, out_ready,
    output in_ready, out_valid, out_data, out_rd, out_overflow, out_zero, out_illegal
  );
endinterface

// File: rtl/alu_param.sv
// Width-parametric combinational ALU shared by the R-type and future I-type units.
module alu_param
  import r_type_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;

  // Result select; overflow only on the trapping add/sub variants.
  always_comb begin
    sum_s    = a + b;
    diff_s   = a - b;
    result   = ZERO;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        result   = sum_s;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADDU: result = sum_s;
      OP_SUB: begin
        result   = diff_s;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUBU: result = diff_s;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
      default: result = ZERO;
    endcase
    zero = (result == ZERO);
  end

endmodule

// File: rtl/r_type_pipe.sv
// Two-stage R-type execution unit: register file, operand forwarding, ALU and
// guarded writeback behind valid/ready handshakes, plus an idle-only debug port.
module r_type_pipe
  import r_type_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  r_type_if.slave          bus,
  output logic             busy,
  input  logic             dbg_we,
  input  logic [AW-1:0]    dbg_addr,
  input  logic [WIDTH-1:0] dbg_wdata,
  output logic [WIDTH-1:0] dbg_rdata
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [AW-1:0]    REG0   = {AW{1'b0}};

  logic [WIDTH-1:0] regs_r [DEPTH];

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [3:0]       s1_op_r;
  logic [AW-1:0]    s1_rd_r;

  logic             s2_valid_r;
  logic [WIDTH-1:0] s2_data_r;
  logic [AW-1:0]    s2_rd_r;
  logic             s2_ovf_r;
  logic             s2_zero_r;
  logic             s2_ill_r;

  logic [WIDTH-1:0] alu_result_s;
  logic             alu_ovf_s;
  logic             alu_zero_s;
  logic             s1_ill_s;
  logic             s2_load_s;
  logic             s1_adv_s;
  logic             in_ready_s;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic             s1_wr_s;
  logic             s2_wr_s;
  logic             wb_en_s;
  logic             dbg_en_s;
  logic [WIDTH-1:0] op_a_s;
  logic [WIDTH-1:0] op_b_s;

  alu_param #(.WIDTH(WIDTH)) u_alu (
    .a        (s1_a_r),
    .b        (s1_b_r),
    .op       (s1_op_r),
    .result   (alu_result_s),
    .overflow (alu_ovf_s),
    .zero     (alu_zero_s)
  );

  assign s1_ill_s   = (s1_op_r == OP_ILL);
  assign s2_load_s  = !s2_valid_r || bus.out_ready;
  assign s1_adv_s   = s1_valid_r && s2_load_s;
  assign in_ready_s = !s1_valid_r || s1_adv_s;
  assign in_xfer_s  = bus.in_valid && in_ready_s;
  assign out_xfer_s = s2_valid_r && bus.out_ready;

  // A stage only forwards when its result will actually be committed.
  assign s1_wr_s  = s1_valid_r && !alu_ovf_s && !s1_ill_s && (s1_rd_r != REG0);
  assign s2_wr_s  = s2_valid_r && !s2_ovf_r && !s2_ill_r && (s2_rd_r != REG0);
  assign wb_en_s  = out_xfer_s && !s2_ovf_r && !s2_ill_r && (s2_rd_r != REG0);
  assign dbg_en_s = dbg_we && !busy && !in_xfer_s && (dbg_addr != REG0);

  assign busy             = s1_valid_r || s2_valid_r;
  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = s2_valid_r;
  assign bus.out_data     = s2_data_r;
  assign bus.out_rd       = s2_rd_r;
  assign bus.out_overflow = s2_ovf_r;
  assign bus.out_zero     = s2_zero_r;
  assign bus.out_illegal  = s2_ill_r;

  // Operand select: youngest writing producer first, then the register file.
  always_comb begin
    op_a_s = ZERO_W;
    op_b_s = ZERO_W;
    if (bus.rs == REG0) begin
      op_a_s = ZERO_W;
    end else if (s1_wr_s && (s1_rd_r == bus.rs)) begin
      op_a_s = alu_result_s;
    end else if (s2_wr_s && (s2_rd_r == bus.rs)) begin
      op_a_s = s2_data_r;
    end else begin
      op_a_s = regs_r[bus.rs];
    end
    if (bus.rt == REG0) begin
      op_b_s = ZERO_W;
    end else if (s1_wr_s && (s1_rd_r == bus.rt)) begin
      op_b_s = alu_result_s;
    end else if (s2_wr_s && (s2_rd_r == bus.rt)) begin
      op_b_s = s2_data_r;
    end else begin
      op_b_s = regs_r[bus.rt];
    end
  end

  // Debug read shows committed state only.
  always_comb begin
    if (dbg_addr == REG0) begin
      dbg_rdata = ZERO_W;
    end else begin
      dbg_rdata = regs_r[dbg_addr];
    end
  end

  // Register file: reset pattern, retire writeback, idle debug write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= WIDTH'(i);
      end
    end else if (wb_en_s) begin
      regs_r[s2_rd_r] <= s2_data_r;
    end else if (dbg_en_s) begin
      regs_r[dbg_addr] <= dbg_wdata;
    end
  end

  // Stage 1: capture forwarded operands and decoded op.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= ZERO_W;
      s1_b_r     <= ZERO_W;
      s1_op_r    <= OP_ILL;
      s1_rd_r    <= REG0;
    end else if (in_ready_s) begin
      s1_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a_r  <= op_a_s;
        s1_b_r  <= op_b_s;
        s1_op_r <= decode_funct(bus.funct);
        s1_rd_r <= bus.rd;
      end
    end
  end

  // Stage 2: result and flags, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= ZERO_W;
      s2_rd_r    <= REG0;
      s2_ovf_r   <= 1'b0;
      s2_zero_r  <= 1'b0;
      s2_ill_r   <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_data_r <= alu_result_s;
        s2_rd_r   <= s1_rd_r;
        s2_ovf_r  <= alu_ovf_s;
        s2_zero_r <= alu_zero_s;
        s2_ill_r  <= s1_ill_s;
      end
    end
  end

endmodule

// File: tb/tb_r_type_pipe.sv
// Directed bench for r_type_pipe: an in-order architectural model predicts every
// result; a per-cycle compare checks handshake, outputs and committed registers.
module tb_r_type_pipe;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          busy;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_wdata;
  logic [W-1:0]  dbg_rdata;

  always #5 clk = ~clk;

  r_type_if #(.WIDTH(W), .AW(AW)) bus ();

  r_type_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata)
  );

  typedef struct {
    logic [W-1:0]  data;
    logic [AW-1:0] rd;
    logic          ovf;
    logic          ill;
    int            acc;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] arch [D];
  logic [W-1:0] comm [D];
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  bit           inited = 1'b0;
  logic [W-1:0] last_data;
  logic         last_ovf;
  logic         last_ill;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      arch[i] = W'(i);
      comm[i] = W'(i);
    end
    q.delete();
  endtask

  // Reference ALU from the instruction definitions (64-bit signed arithmetic).
  task automatic model_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic ovf, output logic ill);
    longint sa, sb, s;
    longint lim_hi, lim_lo;
    lim_hi = 64'sh7FFFFFFF;
    lim_lo = -64'sh80000000;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'h0; ovf = 1'b0; ill = 1'b0;
    case (f)
      6'h20: begin s = sa + sb; r = a + b; ovf = (s > lim_hi) || (s < lim_lo); end
      6'h21: r = a + b;
      6'h22: begin s = sa - sb; r = a - b; ovf = (s > lim_hi) || (s < lim_lo); end
      6'h23: r = a - b;
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h2A: r = (sa < sb) ? 32'h1 : 32'h0;
      6'h2B: r = (a < b) ? 32'h1 : 32'h0;
      default: begin r = 32'h0; ill = 1'b1; end
    endcase
  endtask

  // One clock: compare at the falling edge, then apply this cycle's transfers to the model.
  task automatic tick();
    bit   ov, inx, outx, dodbg;
    exp_t e;
    logic [W-1:0] r;
    logic o, il;
    @(negedge clk);
    if (inited) begin
      ov = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
      chk("out_valid", bus.out_valid, ov);
      if (ov && bus.out_valid) begin
        chk("out_data", bus.out_data, q[0].data);
        chk("out_rd", bus.out_rd, q[0].rd);
        chk("out_overflow", bus.out_overflow, q[0].ovf);
        chk("out_zero", bus.out_zero, q[0].data == 32'h0);
        chk("out_illegal", bus.out_illegal, q[0].ill);
      end
      chk("in_ready", bus.in_ready, (q.size() < 2) || bus.out_ready);
      chk("busy", busy, q.size() > 0);
      chk("dbg_rdata", dbg_rdata, comm[dbg_addr]);
    end
    if (reset) begin
      model_reset();
      inited = 1'b1;
    end else if (inited) begin
      inx   = bus.in_valid && bus.in_ready;
      outx  = bus.out_valid && bus.out_ready;
      dodbg = dbg_we && (q.size() == 0) && !inx && (dbg_addr != 5'd0);
      if (outx && q.size() > 0) begin
        e = q.pop_front();
        last_data = bus.out_data;
        last_ovf  = bus.out_overflow;
        last_ill  = bus.out_illegal;
        if (!e.ovf && !e.ill && e.rd != 5'd0) comm[e.rd] = e.data;
      end
      if (inx) begin
        model_op(bus.funct, arch[bus.rs], arch[bus.rt], r, o, il);
        e.data = r; e.rd = bus.rd; e.ovf = o; e.ill = il; e.acc = cyc;
        q.push_back(e);
        if (!o && !il && bus.rd != 5'd0) arch[bus.rd] = r;
      end
      if (dodbg) begin
        arch[dbg_addr] = dbg_wdata;
        comm[dbg_addr] = dbg_wdata;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [5:0] f);
    bit ok, got;
    got = 1'b0;
    bus.in_valid = 1'b1; bus.rs = s; bus.rt = t; bus.rd = d; bus.funct = f;
    for (int k = 0; k < 20; k++) begin
      ok = bus.in_ready;
      tick();
      if (ok) begin got = 1'b1; break; end
    end
    if (!got) chk("issue_timeout", 1'b0, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (q.size() == 0 && !busy) break;
      tick();
    end
    chk("drain_busy", busy, 1'b0);
  endtask

  task automatic peek(input logic [4:0] a, input logic [W-1:0] exp);
    dbg_addr = a;
    #1;
    chk("peek_reg", dbg_rdata, exp);
  endtask

  task automatic dbg_write(input logic [4:0] a, input logic [W-1:0] d);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    tick();
    dbg_we = 1'b0;
  endtask

  typedef struct packed {
    logic [4:0] s;
    logic [4:0] t;
    logic [4:0] d;
    logic [5:0] f;
  } vec_t;

  initial begin
    vec_t vecs [8];
    bit ok, got;
    logic [W-1:0] hold;

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.rs = 5'd0; bus.rt = 5'd0; bus.rd = 5'd0; bus.funct = 6'h0;
    bus.out_ready = 1'b1;
    dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'h0;
    last_data = 32'h0; last_ovf = 1'b0; last_ill = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("reset_in_ready", bus.in_ready, 1'b1);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_out_data", bus.out_data, 32'h0);

    // add r3 <- r1 + r2, result two cycles after acceptance
    issue(5'd1, 5'd2, 5'd3, 6'h20);
    tick();
    chk("lat_out_valid", bus.out_valid, 1'b1);
    chk("lat_out_data", bus.out_data, 32'd3);
    chk("lat_out_rd", bus.out_rd, 5'd3);
    chk("lat_out_zero", bus.out_zero, 1'b0);
    drain();
    peek(5'd3, 32'd3);

    // back-to-back dependency through S1
    issue(5'd1, 5'd2, 5'd5, 6'h21);
    issue(5'd5, 5'd1, 5'd6, 6'h22);
    drain();
    peek(5'd5, 32'd3);
    peek(5'd6, 32'd2);

    // trapping add writes nothing
    dbg_write(5'd7, 32'h7FFFFFFF);
    dbg_write(5'd1, 32'h1);
    peek(5'd7, 32'h7FFFFFFF);
    issue(5'd7, 5'd1, 5'd8, 6'h20);
    tick();
    chk("ovf_data", bus.out_data, 32'h80000000);
    chk("ovf_flag", bus.out_overflow, 1'b1);
    drain();
    peek(5'd8, 32'd8);

    // backpressure: two accepted, third waits, outputs held
    bus.out_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd20, 6'h21);
    issue(5'd20, 5'd1, 5'd21, 6'h21);
    bus.in_valid = 1'b1; bus.rs = 5'd21; bus.rt = 5'd1; bus.rd = 5'd22; bus.funct = 6'h21;
    chk("bp_in_ready", bus.in_ready, 1'b0);
    hold = bus.out_data;
    tick(); tick();
    chk("bp_hold_data", bus.out_data, hold);
    chk("bp_data", bus.out_data, 32'd3);
    bus.out_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      ok = bus.in_ready;
      tick();
      if (ok) begin got = 1'b1; break; end
    end
    if (!got) chk("bp_accept_timeout", 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    drain();
    chk("bp_in_ready_back", bus.in_ready, 1'b1);
    peek(5'd22, 32'd5);

    // illegal funct, r0 destination, signed/unsigned compare
    issue(5'd1, 5'd2, 5'd11, 6'h3F);
    drain();
    chk("ill_flag", last_ill, 1'b1);
    chk("ill_data", last_data, 32'h0);
    peek(5'd11, 32'd11);
    issue(5'd1, 5'd2, 5'd0, 6'h27);
    drain();
    peek(5'd0, 32'h0);
    dbg_write(5'd10, 32'hFFFFFFFF);
    issue(5'd10, 5'd1, 5'd9, 6'h2A);
    issue(5'd10, 5'd1, 5'd12, 6'h2B);
    drain();
    peek(5'd9, 32'd1);
    peek(5'd12, 32'd0);

    // remaining ops back to back, including a trapping sub
    dbg_write(5'd14, 32'h80000000);
    vecs[0] = '{s: 5'd14, t: 5'd1,  d: 5'd13, f: 6'h22};
    vecs[1] = '{s: 5'd2,  t: 5'd3,  d: 5'd15, f: 6'h23};
    vecs[2] = '{s: 5'd10, t: 5'd2,  d: 5'd16, f: 6'h24};
    vecs[3] = '{s: 5'd2,  t: 5'd4,  d: 5'd17, f: 6'h25};
    vecs[4] = '{s: 5'd10, t: 5'd3,  d: 5'd18, f: 6'h26};
    vecs[5] = '{s: 5'd0,  t: 5'd0,  d: 5'd19, f: 6'h27};
    vecs[6] = '{s: 5'd19, t: 5'd15, d: 5'd23, f: 6'h21};
    vecs[7] = '{s: 5'd23, t: 5'd23, d: 5'd25, f: 6'h20};
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].s, vecs[i].t, vecs[i].d, vecs[i].f);
    end
    drain();
    peek(5'd13, 32'd13);
    peek(5'd15, 32'hFFFFFFFF);
    peek(5'd19, 32'hFFFFFFFF);

    // reset with both stages occupied
    bus.out_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd5, 6'h20);
    issue(5'd2, 5'd2, 5'd24, 6'h20);
    tick();
    chk("pre_reset_busy", busy, 1'b1);
    chk("pre_reset_valid", bus.out_valid, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    chk("post_reset_valid", bus.out_valid, 1'b0);
    chk("post_reset_busy", busy, 1'b0);
    peek(5'd5, 32'd5);
    peek(5'd24, 32'd24);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
